memory_access_unit: RTL and testbench

- Memory-side counterpart to the instruction register: owns MAR and MDR, and drives the req/ack handshake to instruction/data memory.
- Supplies fetched words back onto the datapath through mdr_out and signals completion to the control FSM with ready (LC-3 "R").
- Sits between the datapath bus and the memory model/BRAM wrapper.

---
 rtl/memory_access_unit_pkg.sv | 20 ++
 rtl/memory_access_unit_if.sv | 35 +++
 rtl/memory_access_unit_fsm.sv | 131 +++++++++++++
 rtl/memory_access_unit.sv | 85 ++++++++
 tb/tb_memory_access_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg: shared definitions for the LC-3 memory access unit.
//   mau_state_e      : access sequencer state (IDLE, READ, WRITE, DONE)
//   LC3_WORD_W       : native LC-3 word width
//   MEM_TIMEOUT_FILL : value loaded into MDR when a read times out
// -----------------------------------------------------------------------------
package lc3_pkg;

  localparam int LC3_WORD_W = 16;

  localparam logic [LC3_WORD_W-1:0] MEM_TIMEOUT_FILL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mau_state_e;

endpackage : lc3_pkg

// File: rtl/memory_access_unit_if.sv
// -----------------------------------------------------------------------------
// memory_access_unit_if: req/ack bus between the memory access unit and the
// instruction/data memory.
//   mem_addr  : access address (master -> slave)
//   mem_wdata : write data (master -> slave)
//   mem_req   : request, held until mem_ack (master -> slave)
//   mem_we    : 1 = write, valid while mem_req=1 (master -> slave)
//   mem_rdata : read data, valid with mem_ack (slave -> master)
//   mem_ack   : access complete (slave -> master)
// -----------------------------------------------------------------------------
interface memory_access_unit_if
  import lc3_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = LC3_WORD_W
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );

endinterface : memory_access_unit_if

// File: rtl/memory_access_unit_fsm.sv
// -----------------------------------------------------------------------------
// mem_access_fsm: sequencer for one memory access. Owns the state, the
// registered req/we/ready/err outputs and (optionally) the ack timeout counter.
// Build option: ACCESS_TIMEOUT_EN enables the ack timeout; without it an
// access waits for ack indefinitely and err stays 0.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_mio_en, i_r_w: access request and direction (1 = write)
//   i_mem_ack      : completion from memory
//   o_req, o_we    : registered memory request / write enable
//   o_ready        : registered one-cycle completion pulse
//   o_err          : registered sticky timeout flag
//   o_idle         : sequencer is in IDLE (MAR/MDR loads allowed)
//   o_rd_capture   : this edge captures mem_rdata into MDR
//   o_rd_timeout   : this edge ends a read by timeout (MDR gets fill value)
// -----------------------------------------------------------------------------
module mem_access_fsm
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_mio_en,
  input  logic i_r_w,
  input  logic i_mem_ack,
  output logic o_req,
  output logic o_we,
  output logic o_ready,
  output logic o_err,
  output logic o_idle,
  output logic o_rd_capture,
  output logic o_rd_timeout
);

  mau_state_e r_state;
  mau_state_e w_next;
  logic       w_busy;
  logic       w_timeout;
  logic       w_done;
  logic       w_req_d;
  logic       w_we_d;
  logic       r_req;
  logic       r_we;
  logic       r_ready;

  assign w_busy = (r_state == READ) || (r_state == WRITE);

`ifdef ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Counter value k means this is req cycle k+1 without an ack.
  assign w_timeout = w_busy && !i_mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && i_mio_en) r_cnt <= '0;
      else if (w_busy && !i_mem_ack)   r_cnt <= r_cnt + 1'b1;
      if (w_timeout)                   r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  // No timeout in this build: the comparison is constant false for any
  // legal TIMEOUT_CYCLES, so an access waits for ack indefinitely.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign o_err     = 1'b0;
`endif

  assign w_done = w_busy && (i_mem_ack || w_timeout);

  // State register; the outputs are registered alongside it so every port is
  // driven straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_next;
      r_req   <= w_req_d;
      r_we    <= w_we_d;
      r_ready <= w_done;
    end
  end

  // Next-state logic. The direction is encoded in the state itself, so r_w is
  // only looked at in IDLE and later changes have no effect.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (latch).
    w_next = r_state;
    unique case (r_state)
      IDLE:        if (i_mio_en) w_next = i_r_w ? WRITE : READ;
      READ, WRITE: if (w_done)   w_next = DONE;
      DONE:        if (!i_mio_en) w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  // Output decode from the next state: req rises on the edge that leaves IDLE
  // and falls on the edge that enters DONE.
  always_comb begin
    w_req_d = 1'b0;
    w_we_d  = 1'b0;
    unique case (w_next)
      READ:    w_req_d = 1'b1;
      WRITE: begin
        w_req_d = 1'b1;
        w_we_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_req        = r_req;
  assign o_we         = r_we;
  assign o_ready      = r_ready;
  assign o_idle       = (r_state == IDLE);
  assign o_rd_capture = (r_state == READ) && i_mem_ack;
  assign o_rd_timeout = (r_state == READ) && w_timeout;

endmodule : mem_access_fsm

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit: LC-3 MAR/MDR plus req/ack handshake to memory. Loads
// MAR/MDR from the datapath bus while idle, runs one access per mio_en, and
// returns read data through MDR with a one-cycle ready ("R") pulse.
// Build option: ACCESS_TIMEOUT_EN (ack timeout after TIMEOUT_CYCLES req
// cycles; a timed-out read fills MDR with all-ones and sets sticky err).
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus_in           : datapath bus, source for MAR/MDR loads
//   ld_mar, ld_mdr   : load strobes (ld_mdr ignored while mio_en=1)
//   mio_en, r_w      : start an access, direction (1 = write)
//   mar_out, mdr_out : current MAR / MDR
//   ready            : one-cycle access-complete pulse
//   err              : sticky timeout flag
//   mem              : memory bus (master side)
// -----------------------------------------------------------------------------
module memory_access_unit
  import lc3_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = LC3_WORD_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  ld_mar,
  input  logic                  ld_mdr,
  input  logic                  mio_en,
  input  logic                  r_w,
  output logic [ADDR_WIDTH-1:0] mar_out,
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic                  ready,
  output logic                  err,
  memory_access_unit_if.master  mem
);

  logic [ADDR_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic                  w_idle;
  logic                  w_rd_capture;
  logic                  w_rd_timeout;
  logic                  w_req;
  logic                  w_we;

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_mio_en     (mio_en),
    .i_r_w        (r_w),
    .i_mem_ack    (mem.mem_ack),
    .o_req        (w_req),
    .o_we         (w_we),
    .o_ready      (ready),
    .o_err        (err),
    .o_idle       (w_idle),
    .o_rd_capture (w_rd_capture),
    .o_rd_timeout (w_rd_timeout)
  );

  // MAR/MDR only accept bus loads in IDLE; during an access the sole MDR
  // update is the read result (data or timeout fill).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (w_idle && ld_mar) r_mar <= bus_in[ADDR_WIDTH-1:0];

      if (w_rd_capture)                    r_mdr <= mem.mem_rdata;
      else if (w_rd_timeout)               r_mdr <= DATA_WIDTH'(MEM_TIMEOUT_FILL);
      else if (w_idle && ld_mdr && !mio_en) r_mdr <= bus_in;
    end
  end

  assign mar_out       = r_mar;
  assign mdr_out       = r_mdr;
  assign mem.mem_addr  = r_mar;
  assign mem.mem_wdata = r_mdr;
  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_we;

endmodule : memory_access_unit

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit: randomized scoreboard bench for memory_access_unit.
// A behavioural memory responder answers requests after a chosen delay; the
// driver pushes the expected {MAR, MDR, err} of each access into a queue and
// a monitor pops and compares it on every ready pulse.
// Build option: ACCESS_TIMEOUT_EN selects the timeout or the wait-forever test.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] bus_in;
  logic          ld_mar, ld_mdr, mio_en, r_w;
  logic [AW-1:0] mar_out;
  logic [DW-1:0] mdr_out;
  logic          ready, err;

  memory_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  memory_access_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .mar_out(mar_out), .mdr_out(mdr_out),
    .ready(ready), .err(err), .mem(mem_bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] mar;
    logic [DW-1:0] mdr;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem[logic [AW-1:0]];
  logic [DW-1:0] mem_array[logic [AW-1:0]];
  logic          err_model = 1'b0;
  logic [DW-1:0] exp_mdr   = '0;

  // Locations never written read back as address XOR 5A5A.
  function automatic logic [DW-1:0] blank(input logic [AW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : blank(a);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    model_mem[a] = d;
    mem_array[a] = d;
  endtask

  // ---------------- memory responder ----------------
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit mute      = 1'b0;
  bit stray_req = 1'b0;

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (mem_bus.mem_ack) begin
      mem_bus.mem_ack = 1'b0;
    end else if (stray_req) begin
      mem_bus.mem_rdata = 16'h5555;
      mem_bus.mem_ack   = 1'b1;
      stray_req         = 1'b0;
    end else if (mem_bus.mem_req && !mute) begin
      if (wait_cnt >= ack_delay) begin
        if (mem_bus.mem_we) mem_array[mem_bus.mem_addr] = mem_bus.mem_wdata;
        else mem_bus.mem_rdata = mem_array.exists(mem_bus.mem_addr) ?
                                 mem_array[mem_bus.mem_addr] : blank(mem_bus.mem_addr);
        mem_bus.mem_ack = 1'b1;
        wait_cnt        = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: ready=1 with no access outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("mdr_out", 32'(mdr_out), 32'(e.mdr));
        check("mar_out", 32'(mar_out), 32'(e.mar));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic load_mar(input logic [AW-1:0] addr);
    @(negedge clk);
    bus_in = addr;
    ld_mar = 1'b1;
    @(negedge clk);
    ld_mar = 1'b0;
  endtask

  // One complete access. no_ack=1 withholds the ack (timeout read); the
  // caller passes delay=T-1 in that case so the latency rules still hold.
  task automatic access(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit rw, input int delay, input int hold, input bit no_ack);
    int   cycles, reqc;
    bit   seen, first;
    exp_t e;
    @(negedge clk);
    if (rw) begin
      bus_in = data;
      ld_mdr = 1'b1;
      @(negedge clk);
      ld_mdr = 1'b0;
    end
    load_mar(addr);
    ack_delay = delay;
    mute      = no_ack;
    e.mar     = addr;
    if (no_ack) begin
      e.mdr     = '1;
      err_model = 1'b1;
    end else if (rw) begin
      model_mem[addr] = data;
      e.mdr           = data;
    end else begin
      e.mdr = model_read(addr);
    end
    e.err   = err_model;
    exp_mdr = e.mdr;
    exp_q.push_back(e);

    mio_en = 1'b1;
    r_w    = rw;
    cycles = 0; reqc = 0; seen = 0; first = 1;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mem_bus.mem_req) begin
        reqc++;
        if (first) begin
          first = 0;
          check("mem_addr", 32'(mem_bus.mem_addr), 32'(addr));
          check("mem_we", 32'(mem_bus.mem_we), 32'(rw));
          if (rw) check("mem_wdata", 32'(mem_bus.mem_wdata), 32'(data));
        end
      end
      if (ready) begin
        seen = 1;
      end else begin
        // Noise on every control input while the access is in flight.
        ld_mar = 1'($urandom_range(0, 1));
        ld_mdr = 1'($urandom_range(0, 1));
        bus_in = 16'($urandom);
        r_w    = 1'($urandom_range(0, 1));
        mio_en = 1'($urandom_range(0, 1));
      end
    end
    ld_mar = 1'b0;
    ld_mdr = 1'b0;
    check("ready_seen", 32'(seen), 32'd1);
    check("ready_latency", cycles, delay + 2);
    check("req_cycles", reqc, delay + 1);

    mio_en = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_no_req", 32'(mem_bus.mem_req), 32'd0);
      check("held_no_ready", 32'(ready), 32'd0);
    end
    mio_en = 1'b0;
    mute   = 1'b0;
    @(negedge clk);
  endtask

  task automatic stray_ack_test(input string tag);
    int readyc;
    stray_req = 1'b1;
    readyc    = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) readyc++;
    end
    check({tag, "_mdr"}, 32'(mdr_out), 32'(exp_mdr));
    check({tag, "_ready"}, readyc, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int reqc, readyc;
    rst_n  = 1'b0;
    bus_in = '0;
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mar", 32'(mar_out), 0);
    check("rst_mdr", 32'(mdr_out), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_err", 32'(err), 0);
    check("rst_req", 32'(mem_bus.mem_req), 0);
    check("rst_we", 32'(mem_bus.mem_we), 0);
    rst_n = 1'b1;

    // Directed: read with 3 req cycles, same-cycle-ack write, held mio_en.
    preload(16'h3000, 16'h1234);
    access(16'h3000, '0, 1'b0, 2, 0, 1'b0);
    access(16'h4000, 16'hBEEF, 1'b1, 0, 0, 1'b0);
    access(16'h4000, '0, 1'b0, 1, 10, 1'b0);

    // Stray ack in IDLE must not touch MDR or raise ready.
    stray_ack_test("stray_idle");

    // Randomized mix of reads and writes over a small address window.
    for (int n = 0; n < 40; n++) begin
      access(16'h3000 + 16'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a read.
    mute = 1'b1;
    load_mar(16'h3005);
    mio_en = 1'b1;
    r_w    = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_req", 32'(mem_bus.mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_bus.mem_req), 0);
    check("async_rst_mar", 32'(mar_out), 0);
    check("async_rst_mdr", 32'(mdr_out), 0);
    check("async_rst_ready", 32'(ready), 0);
    mio_en = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    mute    = 1'b0;
    exp_mdr = '0;
    stray_ack_test("stray_after_reset");

`ifdef ACCESS_TIMEOUT_EN
    // Read with no ack: ready after T req cycles, MDR all-ones, err sticky.
    access(16'h3002, '0, 1'b0, T - 1, 0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      access(16'h3000 + 16'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("err_cleared_by_reset", 32'(err), 0);
    rst_n     = 1'b1;
    err_model = 1'b0;
    access(16'h3001, '0, 1'b0, 1, 0, 1'b0);
`else
    // Without the timeout the request is held indefinitely.
    mute = 1'b1;
    load_mar(16'h3002);
    mio_en = 1'b1;
    r_w    = 1'b0;
    reqc   = 0;
    readyc = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_bus.mem_req) reqc++;
      if (ready) readyc++;
    end
    check("hang_req_cycles", reqc, 20);
    check("hang_no_ready", readyc, 0);
    check("hang_err", 32'(err), 0);
    rst_n  = 1'b0;
    mio_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mute  = 1'b0;
    access(16'h3001, '0, 1'b0, 1, 0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memory_access_unit
